// File: rtl/rx78_clk_pkg.sv
// rtl/rx78_clk_pkg.sv - shared types and defaults for the RX-78 clock/reset generator
package rx78_clk_pkg;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_RUN    = 2'd3
    } rx78_state_e;

    // 20 MHz source: 4 MHz CPU, 5 MHz pixel, 2 MHz sound
    localparam int DEF_CPU_DIV     = 5;
    localparam int DEF_PIX_DIV     = 4;
    localparam int DEF_SND_DIV     = 10;
    localparam int DEF_LOCK_CYCLES = 1024;
    localparam int DEF_RST_HOLD    = 64;

    // Width of the shared lock/hold counter; never narrower than one bit
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/rx78_ce_div.sv
// rtl/rx78_ce_div.sv - free-running divider producing a registered one-cycle clock enable
module rx78_ce_div
    import rx78_clk_pkg::*;
#(
    parameter int DIV = DEF_CPU_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic ce
);

    localparam int            W    = $clog2(DIV);
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         ce_q, ce_d;

    // Count 0..DIV-1 while running; the pulse is registered so it lands one edge after the terminal count
    always_comb begin
        cnt_d = '0;
        ce_d  = 1'b0;
        if (run) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                ce_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    // Divider state with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ce_q  <= ce_d;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/rx78_clk_rst_gen.sv
// rtl/rx78_clk_rst_gen.sv - PLL lock qualification, core reset sequencing and clock-enable generation
module rx78_clk_rst_gen
    import rx78_clk_pkg::*;
#(
    parameter int CPU_DIV     = DEF_CPU_DIV,
    parameter int PIX_DIV     = DEF_PIX_DIV,
    parameter int SND_DIV     = DEF_SND_DIV,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int RST_HOLD    = DEF_RST_HOLD
) (
    input  logic clk,
    input  logic rst,
    input  logic locked,
    input  logic reset_req,
    input  logic pause,
    output logic core_rst,
    output logic ready,
    output logic ce_cpu,
    output logic ce_pix,
    output logic ce_snd
);

    localparam int            CW        = cnt_width(LOCK_CYCLES, RST_HOLD);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);

    logic          lk_meta_q;
    logic          lk_s_q;
    rx78_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          core_rst_q, ready_q;
    logic          div_run;
    logic          ce_cpu_raw, ce_pix_raw, ce_snd_raw;

    // Two-flop synchronizer for the asynchronous PLL lock flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lk_meta_q <= 1'b0;
            lk_s_q    <= 1'b0;
        end else begin
            lk_meta_q <= locked;
            lk_s_q    <= lk_meta_q;
        end
    end

    // Next-state logic: lock loss always wins, reset_req restarts the hold window
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_WAIT: begin
                if (lk_s_q) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (!lk_s_q) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HOLD: begin
                if (!lk_s_q) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else if (reset_req) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                if (!lk_s_q) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else if (reset_req) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM registers with outputs decoded from the next state so they change on the transition edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_WAIT;
            cnt_q      <= '0;
            core_rst_q <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            core_rst_q <= (state_d != ST_RUN);
            ready_q    <= (state_d == ST_RUN);
        end
    end

    // Dividers advance only while staying in HOLD/RUN: they sit at zero on HOLD entry and stop on the lock-loss edge
    always_comb begin
        div_run = ((state_q == ST_HOLD) || (state_q == ST_RUN)) &&
                  ((state_d == ST_HOLD) || (state_d == ST_RUN));
    end

    rx78_ce_div #(.DIV(CPU_DIV)) u_div_cpu (
        .clk (clk),
        .rst (rst),
        .run (div_run),
        .ce  (ce_cpu_raw)
    );

    rx78_ce_div #(.DIV(PIX_DIV)) u_div_pix (
        .clk (clk),
        .rst (rst),
        .run (div_run),
        .ce  (ce_pix_raw)
    );

    rx78_ce_div #(.DIV(SND_DIV)) u_div_snd (
        .clk (clk),
        .rst (rst),
        .run (div_run),
        .ce  (ce_snd_raw)
    );

    // Pause masks only the CPU and sound pulses; their counters keep phase underneath
    assign ce_cpu   = ce_cpu_raw & ~pause;
    assign ce_pix   = ce_pix_raw;
    assign ce_snd   = ce_snd_raw & ~pause;
    assign core_rst = core_rst_q;
    assign ready    = ready_q;

endmodule

// File: tb/tb_rx78_clk_rst_gen.sv
// tb/tb_rx78_clk_rst_gen.sv - directed self-checking bench for rx78_clk_rst_gen
module tb_rx78_clk_rst_gen;

    logic clk = 1'b0;
    logic rst, locked, reset_req, pause;
    logic core_rst, ready, ce_cpu, ce_pix, ce_snd;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    rx78_clk_rst_gen dut (
        .clk       (clk),
        .rst       (rst),
        .locked    (locked),
        .reset_req (reset_req),
        .pause     (pause),
        .core_rst  (core_rst),
        .ready     (ready),
        .ce_cpu    (ce_cpu),
        .ce_pix    (ce_pix),
        .ce_snd    (ce_snd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called right after locked is driven high at a negedge; sample i is taken after edge E(i)
    task automatic measure_release(output int fall, output int rdy,
                                   output int fcpu, output int fpix, output int fsnd);
        fall = -1; rdy = -1; fcpu = -1; fpix = -1; fsnd = -1;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (fall < 0 && !core_rst) fall = i;
            if (rdy  < 0 && ready)     rdy  = i;
            if (fcpu < 0 && ce_cpu)    fcpu = i;
            if (fpix < 0 && ce_pix)    fpix = i;
            if (fsnd < 0 && ce_snd)    fsnd = i;
        end
    endtask

    int fall, rdy, fcpu, fpix, fsnd;
    int n_cpu, n_pix, n_snd, wide;
    int p_cpu, p_pix, p_snd;
    int hi_cnt, first_hi, last_pix, pix_bad;
    int last_cpu, first_cpu, low_seen, found;

    initial begin
        rst = 1'b1; locked = 1'b0; reset_req = 1'b0; pause = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_core_rst", int'(core_rst), 1);
        check_eq("rst_ready", int'(ready), 0);
        check_eq("rst_ces", int'({ce_cpu, ce_pix, ce_snd}), 0);

        // Clean start: locked from cycle 5 after release
        rst = 1'b0;
        repeat (5) @(negedge clk);
        locked = 1'b1;
        measure_release(fall, rdy, fcpu, fpix, fsnd);
        check_eq("start_core_rst_fall", fall, 1090);
        check_eq("start_ready_rise", rdy, 1090);
        check_eq("start_first_ce_cpu", fcpu, 1031);
        check_eq("start_first_ce_pix", fpix, 1030);
        check_eq("start_first_ce_snd", fsnd, 1036);

        // Enable rates over 200 cycles in RUN, and no pulse wider than one cycle
        n_cpu = 0; n_pix = 0; n_snd = 0; wide = 0;
        p_cpu = int'(ce_cpu); p_pix = int'(ce_pix); p_snd = int'(ce_snd);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n_cpu += int'(ce_cpu);
            n_pix += int'(ce_pix);
            n_snd += int'(ce_snd);
            if ((ce_cpu && p_cpu == 1) || (ce_pix && p_pix == 1) || (ce_snd && p_snd == 1)) wide++;
            p_cpu = int'(ce_cpu); p_pix = int'(ce_pix); p_snd = int'(ce_snd);
        end
        check_eq("rate_ce_cpu", n_cpu, 40);
        check_eq("rate_ce_pix", n_pix, 50);
        check_eq("rate_ce_snd", n_snd, 20);
        check_eq("pulse_width_wide", wide, 0);

        // Reset request: one-cycle pulse, core_rst high for 64 cycles, ce_pix period preserved
        last_pix = -1; pix_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ce_pix) begin
                if (last_pix >= 0 && cyc - last_pix != 4) pix_bad++;
                last_pix = cyc;
            end
        end
        reset_req = 1'b1;
        @(negedge clk);
        reset_req = 1'b0;
        first_hi = int'(core_rst);
        hi_cnt = 0;
        for (int i = 0; i < 150; i++) begin
            if (i > 0) @(negedge clk);
            hi_cnt += int'(core_rst);
            if (ce_pix) begin
                if (last_pix >= 0 && cyc - last_pix != 4) pix_bad++;
                last_pix = cyc;
            end
        end
        check_eq("rreq_core_rst_next_edge", first_hi, 1);
        check_eq("rreq_core_rst_cycles", hi_cnt, 64);
        check_eq("rreq_pix_period_errors", pix_bad, 0);
        check_eq("rreq_ready_after", int'(ready), 1);

        // Pause for 100 cycles
        last_cpu = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ce_cpu) last_cpu = cyc;
        end
        pause = 1'b1;
        n_cpu = 0; n_pix = 0; n_snd = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_cpu += int'(ce_cpu);
            n_pix += int'(ce_pix);
            n_snd += int'(ce_snd);
        end
        pause = 1'b0;
        first_cpu = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (first_cpu < 0 && ce_cpu) first_cpu = cyc;
        end
        check_eq("pause_ce_cpu", n_cpu, 0);
        check_eq("pause_ce_snd", n_snd, 0);
        check_eq("pause_ce_pix", n_pix, 25);
        check_eq("pause_cpu_phase", (first_cpu >= 0 && last_cpu >= 0) ? (first_cpu - last_cpu) % 5 : -1, 0);

        // Asynchronous reset between edges while a ce_pix pulse is high
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk);
            if (ce_pix) found = 1;
        end
        check_eq("arst_pre_ready", int'(ready), 1);
        check_eq("arst_pre_ce_pix", int'(ce_pix), 1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_core_rst", int'(core_rst), 1);
        check_eq("arst_ready", int'(ready), 0);
        check_eq("arst_ces", int'({ce_cpu, ce_pix, ce_snd}), 0);

        // Lock glitch midway through SETTLE restarts the full count
        locked = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        locked = 1'b1;
        low_seen = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!core_rst || ready) low_seen++;
        end
        locked = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!core_rst || ready) low_seen++;
        end
        locked = 1'b1;
        measure_release(fall, rdy, fcpu, fpix, fsnd);
        check_eq("glitch_core_rst_held", low_seen, 0);
        check_eq("glitch_core_rst_fall", fall, 1090);
        check_eq("glitch_ready_rise", rdy, 1090);
        check_eq("glitch_first_ce_cpu", fcpu, 1031);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
